// File: rtl/xframeunpad_pkg.sv
// Shared definitions for the frame un-padder: ceil-log2 helper and FSM state encoding.
package xframeunpad_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/xframeunpad.sv
// Strips padding from fixed-length frames: forwards the first keep samples of each
// frame, closes the output frame with o_tail and flags framing errors on o_err.
module xframeunpad
  import xframeunpad_pkg::*;
#(
  parameter  int BWID             = 16,
  parameter  int N_FRAME_LENGTH   = 1024,
  parameter  int N_MAX_BEFORE_PAD = 256,
  localparam int LWID             = clog2(N_MAX_BEFORE_PAD) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BWID-1:0] iv_data,
  input  logic            i_nd,
  input  logic            i_head,
  input  logic            i_tail,
  input  logic [LWID-1:0] iv_len,
  output logic [BWID-1:0] ov_data,
  output logic            o_dv,
  output logic            o_head,
  output logic            o_tail,
  output logic            o_err
);

  localparam int IWID = clog2(N_FRAME_LENGTH) + 1;
  localparam logic [IWID-1:0] LAST_IDX = IWID'(N_FRAME_LENGTH - 1);
  localparam logic [LWID-1:0] MAX_KEEP = LWID'(N_MAX_BEFORE_PAD);

  generate
    if (N_FRAME_LENGTH < 2 || N_MAX_BEFORE_PAD < 1 || N_MAX_BEFORE_PAD > N_FRAME_LENGTH) begin : g_bad_params
      $error("xframeunpad: illegal N_FRAME_LENGTH / N_MAX_BEFORE_PAD combination");
    end
  endgenerate

  state_t            state_reg;
  logic [IWID-1:0]   idx_reg;
  logic [LWID-1:0]   keep_reg;
  logic [LWID-1:0]   keep_next;
  logic              keep_last;
  logic              frame_end;

  // Payload length clamped into 1..N_MAX_BEFORE_PAD; the head sample is always kept.
  always_comb begin
    keep_next = iv_len;
    if (iv_len == '0) begin
      keep_next = LWID'(1);
    end else if (iv_len > MAX_KEEP) begin
      keep_next = MAX_KEEP;
    end
  end

  assign keep_last = (idx_reg == (IWID'(keep_reg) - IWID'(1)));
  assign frame_end = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      keep_reg  <= LWID'(1);
      ov_data   <= '0;
      o_dv      <= 1'b0;
      o_head    <= 1'b0;
      o_tail    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_dv   <= 1'b0;
      o_head <= 1'b0;
      o_tail <= 1'b0;
      o_err  <= 1'b0;
      if (i_nd) begin
        if (i_head) begin
          // A head always starts a fresh frame; arriving mid-frame aborts the open one.
          keep_reg <= keep_next;
          ov_data  <= iv_data;
          o_dv     <= 1'b1;
          o_head   <= 1'b1;
          o_err    <= (state_reg != ST_IDLE) || i_tail;
          if (i_tail) begin
            o_tail    <= 1'b1;
            idx_reg   <= '0;
            state_reg <= ST_IDLE;
          end else if (keep_next == LWID'(1)) begin
            o_tail    <= 1'b1;
            idx_reg   <= IWID'(1);
            state_reg <= ST_DROP;
          end else begin
            idx_reg   <= IWID'(1);
            state_reg <= ST_PASS;
          end
        end else begin
          case (state_reg)
            ST_IDLE: begin
              state_reg <= ST_IDLE;
            end
            ST_PASS: begin
              ov_data <= iv_data;
              o_dv    <= 1'b1;
              o_tail  <= keep_last || i_tail;
              if (frame_end || i_tail) begin
                o_err     <= frame_end ? !i_tail : 1'b1;
                idx_reg   <= '0;
                state_reg <= ST_IDLE;
              end else begin
                idx_reg   <= idx_reg + IWID'(1);
                state_reg <= keep_last ? ST_DROP : ST_PASS;
              end
            end
            ST_DROP: begin
              if (frame_end || i_tail) begin
                o_err     <= frame_end ? !i_tail : 1'b1;
                idx_reg   <= '0;
                state_reg <= ST_IDLE;
              end else begin
                idx_reg   <= idx_reg + IWID'(1);
              end
            end
            default: begin
              idx_reg   <= '0;
              state_reg <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_xframeunpad.sv
// Self-checking bench: two un-padder instances (max keep 4 and 8, frame length 8)
// driven in parallel and compared cycle by cycle against a frame-level reference model.
module tb_xframeunpad;

  localparam int NFL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iv_data;
  logic        i_nd;
  logic        i_head;
  logic        i_tail;
  logic [3:0]  iv_len;

  logic [15:0] ov_data_a, ov_data_b;
  logic        o_dv_a, o_head_a, o_tail_a, o_err_a;
  logic        o_dv_b, o_head_b, o_tail_b, o_err_b;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  xframeunpad #(.BWID(16), .N_FRAME_LENGTH(NFL), .N_MAX_BEFORE_PAD(4)) dut_a (
    .clk(clk), .rst(rst), .iv_data(iv_data), .i_nd(i_nd), .i_head(i_head), .i_tail(i_tail),
    .iv_len(iv_len[2:0]), .ov_data(ov_data_a), .o_dv(o_dv_a), .o_head(o_head_a),
    .o_tail(o_tail_a), .o_err(o_err_a)
  );

  xframeunpad #(.BWID(16), .N_FRAME_LENGTH(NFL), .N_MAX_BEFORE_PAD(8)) dut_b (
    .clk(clk), .rst(rst), .iv_data(iv_data), .i_nd(i_nd), .i_head(i_head), .i_tail(i_tail),
    .iv_len(iv_len), .ov_data(ov_data_b), .o_dv(o_dv_b), .o_head(o_head_b),
    .o_tail(o_tail_b), .o_err(o_err_b)
  );

  // Reference model: per instance, whether a frame is open, the sample position in it,
  // the clamped keep count and the last emitted payload word.
  int          nmax [2] = '{4, 8};
  bit          m_open [2];
  int          m_pos [2];
  int          m_keep [2];
  logic [15:0] m_data [2];
  bit          e_dv [2];
  bit          e_head [2];
  bit          e_tail [2];
  bit          e_err [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_open[m] = 0; m_pos[m] = 0; m_keep[m] = 1; m_data[m] = '0;
      e_dv[m] = 0; e_head[m] = 0; e_tail[m] = 0; e_err[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int len;
    int p;
    bit kept;
    e_dv[m] = 0; e_head[m] = 0; e_tail[m] = 0; e_err[m] = 0;
    len = (m == 0) ? int'(iv_len[2:0]) : int'(iv_len);
    if (i_nd && i_head) begin
      e_err[m]  = m_open[m];
      m_keep[m] = (len < 1) ? 1 : ((len > nmax[m]) ? nmax[m] : len);
      e_dv[m] = 1; e_head[m] = 1; m_data[m] = iv_data;
      if (i_tail) begin
        e_tail[m] = 1; e_err[m] = 1; m_open[m] = 0;
      end else begin
        e_tail[m] = (m_keep[m] == 1); m_open[m] = 1; m_pos[m] = 1;
      end
    end else if (i_nd && m_open[m]) begin
      p = m_pos[m];
      kept = (p < m_keep[m]);
      if (kept) begin
        e_dv[m] = 1; m_data[m] = iv_data; e_tail[m] = (p == m_keep[m] - 1);
      end
      if (p == NFL - 1) begin
        e_err[m] = !i_tail; m_open[m] = 0;
      end else if (i_tail) begin
        e_err[m] = 1; m_open[m] = 0;
        if (kept) e_tail[m] = 1;
      end
      m_pos[m] = p + 1;
    end
  endtask

  task automatic chk(input string tag, input string sig, input int m,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s[%0d] observed=%h expected=%h", tag, sig, m, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "dv",   0, 16'(o_dv_a),   16'(e_dv[0]));
    chk(tag, "head", 0, 16'(o_head_a), 16'(e_head[0]));
    chk(tag, "tail", 0, 16'(o_tail_a), 16'(e_tail[0]));
    chk(tag, "err",  0, 16'(o_err_a),  16'(e_err[0]));
    chk(tag, "data", 0, ov_data_a,     m_data[0]);
    chk(tag, "dv",   1, 16'(o_dv_b),   16'(e_dv[1]));
    chk(tag, "head", 1, 16'(o_head_b), 16'(e_head[1]));
    chk(tag, "tail", 1, 16'(o_tail_b), 16'(e_tail[1]));
    chk(tag, "err",  1, 16'(o_err_b),  16'(e_err[1]));
    chk(tag, "data", 1, ov_data_b,     m_data[1]);
  endtask

  // Drive one cycle of input, advance the model, then compare 1 clk later.
  task automatic step(input bit nd, input bit hd, input bit tl, input int len,
                      input logic [15:0] data, input string tag);
    i_nd = nd; i_head = hd; i_tail = tl; iv_len = 4'(len); iv_data = data;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // One padded frame of samples 1..8; tail_at/head2_at = 0 means none.
  task automatic frame8(input int len, input int tail_at, input int head2_at, input string tag);
    for (int k = 1; k <= NFL; k++) begin
      step(1'b1, (k == 1) || (k == head2_at), (k == tail_at), len, 16'(k), tag);
    end
  endtask

  initial begin
    int gen_pos;
    bit nd, hd, tl;
    rst = 1'b1; i_nd = 0; i_head = 0; i_tail = 0; iv_len = '0; iv_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 1'b0, 3, 16'h00aa, "stray_idle");
    frame8(3, 8, 0, "nominal");
    frame8(7, 8, 0, "clamp");
    frame8(0, 8, 0, "min");
    frame8(8, 8, 0, "full_keep");
    frame8(4, 8, 0, "back_to_back");
    step(1'b0, 1'b0, 1'b0, 0, 16'h0, "gap");
    frame8(4, 3, 0, "early_tail");
    frame8(3, 8, 0, "after_early");
    frame8(3, 0, 0, "missing_tail");
    frame8(2, 8, 6, "stray_head");
    step(1'b1, 1'b1, 1'b1, 3, 16'h0055, "head_tail");
    step(1'b0, 1'b0, 1'b0, 0, 16'h0, "gap");

    // Asynchronous reset between clock edges while both instances are in PASS.
    step(1'b1, 1'b1, 1'b0, 4, 16'd1, "pre_reset");
    step(1'b1, 1'b0, 1'b0, 4, 16'd2, "pre_reset");
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    i_nd = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 3; k <= NFL; k++) begin
      step(1'b1, 1'b0, (k == NFL), 4, 16'(k), "post_reset");
    end
    frame8(3, 8, 0, "recover");

    // Random traffic: mostly well-formed frames with gaps, occasional framing faults.
    gen_pos = 0;
    for (int c = 0; c < 600; c++) begin
      nd = ($urandom_range(0, 3) != 0);
      hd = 0; tl = 0;
      if (nd) begin
        hd = (gen_pos == 0);
        tl = (gen_pos == NFL - 1);
        if ($urandom_range(0, 40) == 0) hd = ~hd;
        if ($urandom_range(0, 40) == 0) tl = ~tl;
        gen_pos = (gen_pos == NFL - 1) ? 0 : gen_pos + 1;
      end
      step(nd, hd, tl, int'($urandom_range(0, 15)), 16'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
